// File: rtl/pipe_mem_pkg.sv
`default_nettype none
// ============================================================================
//  pipe_mem_pkg : MMIO map, register bit indices and decode helper for
//                 the MEM-stage data-memory responder.
//  Revision     : 1.0
// ============================================================================
package pipe_mem_pkg;

    localparam logic       MMIO_BASE = 1'b1;

    localparam logic [7:0] OFF_OUT   = 8'h00;
    localparam logic [7:0] OFF_IN    = 8'h04;
    localparam logic [7:0] OFF_CYCLE = 8'h08;
    localparam logic [7:0] OFF_CMP   = 8'h0C;
    localparam logic [7:0] OFF_CTRL  = 8'h10;
    localparam logic [7:0] OFF_CNT   = 8'h14;
    localparam logic [7:0] OFF_ERRST = 8'h18;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_RELOAD  = 1;
    localparam int CTRL_FLAG    = 2;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_UNMAPPED = 1;

    typedef enum logic [2:0] {
        REG_OUT,
        REG_IN,
        REG_CYCLE,
        REG_CMP,
        REG_CTRL,
        REG_CNT,
        REG_ERRST,
        REG_NONE
    } mmio_reg_e;

    // Byte lane bits are ignored; anything past ERRST is unmapped.
    function automatic mmio_reg_e mmio_decode(input logic [7:0] off);
        case (off & 8'hFC)
            OFF_OUT:   return REG_OUT;
            OFF_IN:    return REG_IN;
            OFF_CYCLE: return REG_CYCLE;
            OFF_CMP:   return REG_CMP;
            OFF_CTRL:  return REG_CTRL;
            OFF_CNT:   return REG_CNT;
            OFF_ERRST: return REG_ERRST;
            default:   return REG_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_timer.sv
`default_nettype none
// ============================================================================
//  pipe_timer : compare timer (CNT/CMP/EN/RELOAD/FLAG) with W1C flag and irq.
//  Revision   : 1.0
// ============================================================================
module pipe_timer
    import pipe_mem_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        wr_cmp,
    input  logic        wr_ctrl,
    input  logic        wr_cnt,
    input  logic [31:0] wr_data,
    output logic [31:0] cnt,
    output logic [31:0] cmp,
    output logic        en,
    output logic        reload,
    output logic        flag,
    output logic        irq
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        reload_q, reload_d;
    logic        flag_q, flag_d;
    logic        hit;

    assign hit = en_q && (cnt_q == cmp_q);

    always_comb begin
        cnt_d    = cnt_q;
        cmp_d    = cmp_q;
        en_d     = en_q;
        reload_d = reload_q;

        if (en_q) begin
            if (hit) begin
                if (reload_q) cnt_d = 32'd0;
                else          en_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        // Software writes override the timer's own update.
        if (wr_cmp) cmp_d = wr_data;
        if (wr_cnt) cnt_d = wr_data;
        if (wr_ctrl) begin
            en_d     = wr_data[CTRL_EN];
            reload_d = wr_data[CTRL_RELOAD];
        end

        // A compare hit wins over a same-cycle write-1-to-clear.
        flag_d = (flag_q & ~(wr_ctrl & wr_data[CTRL_FLAG])) | hit;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= 32'd0;
            cmp_q    <= 32'd0;
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            reload_q <= reload_d;
            flag_q   <= flag_d;
        end
    end

    assign cnt    = cnt_q;
    assign cmp    = cmp_q;
    assign en     = en_q;
    assign reload = reload_q;
    assign flag   = flag_q;
    assign irq    = flag_q;

endmodule
`default_nettype wire

// File: rtl/pipe_dmem_io.sv
`default_nettype none
// ============================================================================
//  pipe_dmem_io : word RAM plus MMIO (OUT, IN, CYCLE, timer, ERRST) answering
//                 the MEM stage with zero-latency, side-effect-free reads.
//  Revision     : 1.0
// ============================================================================
module pipe_dmem_io
    import pipe_mem_pkg::*;
#(
    parameter int RAM_AW = 6
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    input  logic [31:0] io_in,
    output logic [31:0] io_out,
    output logic        irq,
    output logic        err
);

    logic [31:0]       ram_q [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;

    logic [31:0] out_q, out_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] sync1_q, sync2_q;
    logic [1:0]  errst_q, errst_d;

    mmio_reg_e   reg_sel;
    logic        is_mmio, ram_hit, mmio_hit, mapped, misalign, wr_ok;
    logic        wr_ram, wr_out, wr_cycle, wr_cmp, wr_ctrl, wr_cnt, wr_errst;
    logic [1:0]  err_set, err_clr;

    logic [31:0] t_cnt, t_cmp;
    logic        t_en, t_reload, t_flag;

    assign is_mmio  = (addr[31] == MMIO_BASE);
    assign reg_sel  = mmio_decode(addr[7:0]);
    assign ram_idx  = addr[RAM_AW+1:2];
    assign ram_hit  = !is_mmio && ((addr[30:0] >> (RAM_AW + 2)) == 31'd0);
    assign mmio_hit = is_mmio && (addr[30:8] == 23'd0) && (reg_sel != REG_NONE);
    assign mapped   = ram_hit || mmio_hit;
    assign misalign = (addr[1:0] != 2'b00);
    assign wr_ok    = we && !misalign && mapped;

    assign wr_ram   = wr_ok && ram_hit;
    assign wr_out   = wr_ok && mmio_hit && (reg_sel == REG_OUT);
    assign wr_cycle = wr_ok && mmio_hit && (reg_sel == REG_CYCLE);
    assign wr_cmp   = wr_ok && mmio_hit && (reg_sel == REG_CMP);
    assign wr_ctrl  = wr_ok && mmio_hit && (reg_sel == REG_CTRL);
    assign wr_cnt   = wr_ok && mmio_hit && (reg_sel == REG_CNT);
    assign wr_errst = wr_ok && mmio_hit && (reg_sel == REG_ERRST);

    always_comb begin
        err_set               = 2'b00;
        err_set[ERR_MISALIGN] = we && misalign;
        err_set[ERR_UNMAPPED] = we && !mapped;
        err_clr               = wr_errst ? datain[1:0] : 2'b00;
        errst_d               = (errst_q & ~err_clr) | err_set;

        out_d   = wr_out ? datain : out_q;
        cycle_d = wr_cycle ? 32'd0 : cycle_q + 32'd1;
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (wr_ram) ram_q[ram_idx] <= datain;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_q   <= 32'd0;
            cycle_q <= 32'd0;
            sync1_q <= 32'd0;
            sync2_q <= 32'd0;
            errst_q <= 2'b00;
        end else begin
            out_q   <= out_d;
            cycle_q <= cycle_d;
            sync1_q <= io_in;
            sync2_q <= sync1_q;
            errst_q <= errst_d;
        end
    end

    pipe_timer u_timer (
        .clock   (clock),
        .resetn  (resetn),
        .wr_cmp  (wr_cmp),
        .wr_ctrl (wr_ctrl),
        .wr_cnt  (wr_cnt),
        .wr_data (datain),
        .cnt     (t_cnt),
        .cmp     (t_cmp),
        .en      (t_en),
        .reload  (t_reload),
        .flag    (t_flag),
        .irq     (irq)
    );

    always_comb begin
        dataout = 32'd0;
        if (ram_hit) begin
            dataout = ram_q[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                REG_OUT:   dataout = out_q;
                REG_IN:    dataout = sync2_q;
                REG_CYCLE: dataout = cycle_q;
                REG_CMP:   dataout = t_cmp;
                REG_CTRL:  dataout = {29'd0, t_flag, t_reload, t_en};
                REG_CNT:   dataout = t_cnt;
                REG_ERRST: dataout = {30'd0, errst_q};
                default:   dataout = 32'd0;
            endcase
        end
    end

    assign io_out = out_q;
    assign err    = |errst_q;

endmodule
`default_nettype wire

// File: doc/pipe_dmem_io.md
# pipe_dmem_io

Data-memory responder for the pipelined CPU's MEM stage: it answers the stage's word-wide load/store interface with a word RAM plus a small memory-mapped I/O region. The I/O region holds an output port, a synchronized input port, a free-running cycle counter, a compare timer with interrupt flag, and a sticky error register. Reads are side-effect free, because the MEM stage presents its ALU result as an address every cycle, including for non-memory instructions.

## Interface

- `RAM_AW`, default 6: RAM word-address width; the RAM depth is 2^RAM_AW words.
- `clock`  in  1: sole clock; all state changes on its rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `we`  in  1: store enable from the MEM stage.
- `addr`  in  32: byte address from the MEM stage's ALU result.
- `datain`  in  32: store data.
- `dataout`  out  32: load data, combinational from `addr` and current state.
- `io_in`  in  32: external input port, asynchronous to `clock`.
- `io_out`  out  32: output port register.
- `irq`  out  1: mirrors the timer flag.
- `err`  out  1: OR of the error status bits.

## Operation

- **Decode.**
  - `addr[31]`=0 selects RAM; the word index is `addr[RAM_AW+1:2]`.
  - RAM space with `addr[30:RAM_AW+2]`≠0 is unmapped.
  - `addr[31]`=1 selects MMIO at offset `addr[7:0]`; `addr[30:8]`≠0 is unmapped.
- **MMIO offsets:**
  - 0x00 OUT: read/write, drives `io_out`.
  - 0x04 IN: read-only; returns the second stage of a 2-flop synchronizer on `io_in`.
  - 0x08 CYCLE: read returns a free-running counter; any write clears it to 0.
  - 0x0C CMP: read/write, timer compare value.
  - 0x10 CTRL: bit0 EN (read/write), bit1 RELOAD (read/write), bit2 FLAG (write 1 to clear); bits 31:3 read 0.
  - 0x14 CNT: read/write, timer count.
  - 0x18 ERRST: bit0 MISALIGN, bit1 UNMAPPED; write 1 to clear; other bits read 0.
  - Offsets 0x1C–0xFF are unmapped.
- **Reads.** `addr[1:0]` is ignored. Unmapped reads return 0. No read alters any state.
- **Writes.**
  - If `we`=1 and `addr[1:0]`≠0: the write is suppressed and MISALIGN is set.
  - If `we`=1 and the address is unmapped: the write is ignored and UNMAPPED is set.
  - Errors are flagged on writes only.
- **Timer.**
  - While EN=1, each cycle: if CNT==CMP, FLAG is set. Then, if RELOAD=1, CNT←0. Otherwise EN←0 and CNT holds.
  - If CNT≠CMP, CNT←CNT+1, wrapping modulo 2^32.
  - While EN=0, CNT holds.
- **Simultaneous events.**
  - A write to CNT or CTRL beats the timer update in the same cycle.
  - A hardware FLAG set beats a same-cycle W1C clear.
  - A hardware error-bit set beats a same-cycle W1C clear of that bit.
  - A write to CYCLE beats its increment.
- **Reset values.**
  - OUT, CYCLE, CMP, CTRL, CNT, ERRST and both synchronizer stages reset to 0.
  - Consequently `io_out`=0, `irq`=0, `err`=0.
  - RAM contents are not reset. Reset asserted mid-operation clears the registers immediately; the RAM keeps its contents.

## Timing

- Load latency is 0 cycles: `dataout` is valid in the same cycle as `addr`, with no wait states and no stall output.
- A write takes effect at the rising edge that ends its cycle. A read of the same location in the next cycle returns the new value.
- CYCLE reads its pre-edge value. After reset release it reads 0, 1, 2, ….
- An `io_in` change becomes visible at IN 2 rising edges after it meets setup.
- `irq` rises the cycle after the edge at which CNT==CMP is sampled with EN=1.

## Structure

- Package `pipe_mem_pkg` holds:
  - MMIO offset constants (OFF_OUT … OFF_ERRST);
  - CTRL bit indices (CTRL_EN, CTRL_RELOAD, CTRL_FLAG);
  - ERRST bit indices;
  - the MMIO base value (`addr[31]`=1).
- Sub-module `pipe_timer` holds CNT, CMP, EN, RELOAD and FLAG, with a write-port interface and an `irq` output.
- The RAM array, decode, CYCLE, OUT, the synchronizer and ERRST live in the top level.

## Test plan

- **RAM round-trip.** Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 → both return 0xDEADBEEF; a read of 0x0000_0014 returns prior contents.
- **Misaligned and unmapped writes.**
  - Write 0x1234 to 0x0000_0012 → RAM word 4 is unchanged, ERRST=0x1, `err`=1.
  - Write to 0x8000_0040 → ERRST=0x3.
  - Write 0x3 to 0x8000_0018 → ERRST=0, `err`=0.
  - A read of 0x8000_0040 returns 0 and leaves ERRST unchanged.
- **One-shot timer.** CMP=5, CNT=0, CTRL=0x1 → CNT reads 0..5; FLAG and `irq` go to 1 the cycle after CNT reads 5; EN reads 0; CNT holds 5. Writing 0x4 to CTRL clears `irq`.
- **Reload timer.** CMP=3, CTRL=0x3 → `irq` sets after 4 cycles; CNT sequence is 0,1,2,3,0,1…. A same-cycle W1C write at a compare hit leaves FLAG=1.
- **Ports and counter.**
  - Write 0xA5 to OUT → `io_out`=0xA5 the next cycle.
  - Drive `io_in`=0x55 → IN reads 0x55 2 cycles later.
  - Write to CYCLE → it reads 0 the next cycle, then 1.
- **Asynchronous reset.** Assert `resetn`=0 mid-count → `io_out`, `irq`, `err` and CNT go to 0 without a clock edge; RAM word 4 still holds 0xDEADBEEF after release.
